// File: rtl/led_dipsw_poller.sv
// Polls a 5-bit DIP-switch PIO, debounces it, and mirrors the result (or a
// rotating one-hot pattern when switch bit 4 is set) back out as an LED write.
module led_dipsw_poller #(
  parameter int POLL_CYCLES    = 50000,
  parameter int DEBOUNCE_COUNT = 4,
  parameter int ROTATE_DIV     = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  output logic [4:0]  sw_value,
  output logic        sw_changed,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [PW-1:0] POLL_LAST   = PW'(POLL_CYCLES - 1);
  localparam logic [3:0]    DB_MAX      = 4'(DEBOUNCE_COUNT);
  localparam logic [7:0]    ROT_LAST_M1 = 8'(ROTATE_DIV - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    EVAL    = 3'd3,
    WR      = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic [4:0]    sample_q, sample_d;
  logic [4:0]    cand_q, cand_d;
  logic [3:0]    db_cnt_q, db_cnt_d;
  logic [4:0]    sw_value_q, sw_value_d;
  logic          sw_changed_q, sw_changed_d;
  logic [3:0]    rot_q, rot_d;
  logic [7:0]    rot_div_q, rot_div_d;
  logic [4:0]    last_led_q, last_led_d;
  logic          force_q, force_d;

  logic          tick;
  logic [4:0]    led_cur;
  logic [4:0]    led_next;
  logic          unused_rd_hi;

  function automatic logic [4:0] led_of(input logic [4:0] sw, input logic [3:0] rot);
    return sw[4] ? {1'b1, rot} : sw;
  endfunction

  assign unused_rd_hi = ^avm_readdata[31:5];
  assign led_cur      = led_of(sw_value_q, rot_q);

  // Poll timebase: held at zero while disabled so re-enabling restarts a full period.
  always_comb begin
    poll_cnt_d = poll_cnt_q;
    tick       = 1'b0;
    if (!enable) begin
      poll_cnt_d = '0;
    end else if (poll_cnt_q == POLL_LAST) begin
      poll_cnt_d = '0;
      tick       = 1'b1;
    end else begin
      poll_cnt_d = poll_cnt_q + 1'b1;
    end
  end

  // PIO bus: no waitrequest; a read presents address 0 in RD_ADDR and the
  // registered readdata is valid (and captured) in RD_DATA; a write is a single
  // WR cycle with chipselect=1, write_n=0.
  always_comb begin
    state_d        = state_q;
    sample_d       = sample_q;
    cand_d         = cand_q;
    db_cnt_d       = db_cnt_q;
    sw_value_d     = sw_value_q;
    sw_changed_d   = 1'b0;
    rot_d          = rot_q;
    rot_div_d      = rot_div_q;
    last_led_d     = last_led_q;
    force_d        = force_q;
    led_next       = led_cur;
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_writedata  = '0;

    case (state_q)
      IDLE: begin
        if (tick) state_d = RD_ADDR;
      end
      RD_ADDR: begin
        avm_chipselect = 1'b1;
        state_d        = RD_DATA;
      end
      RD_DATA: begin
        avm_chipselect = 1'b1;
        sample_d       = avm_readdata[4:0];
        state_d        = EVAL;
      end
      EVAL: begin
        if (sample_q != cand_q) begin
          cand_d   = sample_q;
          db_cnt_d = 4'd1;
        end else if (db_cnt_q < DB_MAX) begin
          db_cnt_d = db_cnt_q + 4'd1;
        end
        if ((db_cnt_d >= DB_MAX) && (cand_d != sw_value_q)) begin
          sw_value_d   = cand_d;
          sw_changed_d = 1'b1;
        end
        // Rotation follows the mode of the value just decided in this poll.
        if (sw_value_d[4]) begin
          if (rot_div_q == ROT_LAST_M1) begin
            rot_div_d = '0;
            rot_d     = {rot_q[2:0], rot_q[3]};
          end else begin
            rot_div_d = rot_div_q + 8'd1;
          end
        end else begin
          rot_d     = 4'b0001;
          rot_div_d = '0;
        end
        led_next = led_of(sw_value_d, rot_d);
        state_d  = ((led_next != last_led_q) || force_q) ? WR : IDLE;
      end
      WR: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_writedata  = {27'b0, led_cur};
        last_led_d     = led_cur;
        force_d        = 1'b0;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      poll_cnt_q   <= '0;
      sample_q     <= '0;
      cand_q       <= '0;
      db_cnt_q     <= '0;
      sw_value_q   <= '0;
      sw_changed_q <= 1'b0;
      rot_q        <= 4'b0001;
      rot_div_q    <= '0;
      last_led_q   <= '0;
      force_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      poll_cnt_q   <= poll_cnt_d;
      sample_q     <= sample_d;
      cand_q       <= cand_d;
      db_cnt_q     <= db_cnt_d;
      sw_value_q   <= sw_value_d;
      sw_changed_q <= sw_changed_d;
      rot_q        <= rot_d;
      rot_div_q    <= rot_div_d;
      last_led_q   <= last_led_d;
      force_q      <= force_d;
    end
  end

  assign avm_address = 2'b00;
  assign sw_value    = sw_value_q;
  assign sw_changed  = sw_changed_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_led_dipsw_poller.sv
// Bench for led_dipsw_poller: per-poll vector table plus hand-written
// enable-drop and reset-during-write sequences, writes checked via a queue.
module tb_led_dipsw_poller;

  localparam int POLL = 16;
  localparam int DB   = 3;
  localparam int RDIV = 2;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR      = 3'd4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [4:0]  sw_value;
  logic        sw_changed;
  logic        busy;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int rd_count = 0;
  int chg_cnt = 0;
  int poll_last_rd = 0;
  logic [31:0] exp_q[$];

  typedef struct packed {
    logic [4:0] din;
    logic       wr_v;
    logic [4:0] wr_d;
    logic [4:0] sw;
    logic       chg;
  } vec_t;

  vec_t vecs [0:23];

  led_dipsw_poller #(
    .POLL_CYCLES(POLL), .DEBOUNCE_COUNT(DB), .ROTATE_DIV(RDIV)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .sw_value(sw_value),
    .sw_changed(sw_changed), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got 0x%0h, expected nothing (t=%0t)", name, act, $time);
  endtask

  // scoreboard: every write strobe must match the head of exp_q
  always @(negedge clk) begin
    if (reset_n) begin
      if (dbg_state == S_RD_ADDR) rd_count++;
      if (sw_changed) chg_cnt++;
      if (avm_chipselect && !avm_write_n) begin
        check("write_addr", {30'b0, avm_address}, 32'h0);
        if (exp_q.size() == 0) fail_now("unexpected_write", avm_writedata);
        else check("write_data", avm_writedata, exp_q.pop_front());
      end
    end
  end

  task automatic wait_state(input logic [2:0] s, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (dbg_state == s) begin
        ok = 1'b1;
        return;
      end
    end
    fail_now($sformatf("wait_state_%0d_timeout", s), {29'b0, dbg_state});
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    fail_now("wait_idle_timeout", {29'b0, dbg_state});
  endtask

  // one complete poll with input din and its expected outcome
  task automatic do_poll(input logic [4:0] din, input logic wv, input logic [4:0] wd,
                         input logic [4:0] sw, input logic chg, input bit chk_period,
                         input string tag);
    logic [31:0] r;
    int c0;
    int rd_cyc;
    bit ok;
    r = $urandom;
    avm_readdata = {r[31:5], din};
    if (wv) exp_q.push_back({27'b0, wd});
    c0 = chg_cnt;
    wait_state(S_RD_ADDR, 3 * POLL, ok);
    rd_cyc = cyc;
    if (ok && chk_period) check({tag, "_period"}, rd_cyc - poll_last_rd, POLL);
    poll_last_rd = rd_cyc;
    wait_idle(10);
    @(negedge clk);
    check({tag, "_sw_value"}, {27'b0, sw}, {27'b0, sw_value});
    check({tag, "_sw_changed_pulses"}, chg_cnt - c0, {31'b0, chg});
    check({tag, "_write_done"}, exp_q.size(), 0);
  endtask

  initial begin
    bit ok;
    int rc0;
    int en_cyc;
    logic [31:0] r;

    vecs = '{
      '{5'h00, 1'b1, 5'h00, 5'h00, 1'b0},  // forced first write
      '{5'h00, 1'b0, 5'h00, 5'h00, 1'b0},
      '{5'h00, 1'b0, 5'h00, 5'h00, 1'b0},  // accepted but equal: no pulse
      '{5'h05, 1'b0, 5'h00, 5'h00, 1'b0},
      '{5'h05, 1'b0, 5'h00, 5'h00, 1'b0},
      '{5'h05, 1'b1, 5'h05, 5'h05, 1'b1},
      '{5'h06, 1'b0, 5'h00, 5'h05, 1'b0},  // bouncing input
      '{5'h05, 1'b0, 5'h00, 5'h05, 1'b0},
      '{5'h06, 1'b0, 5'h00, 5'h05, 1'b0},
      '{5'h05, 1'b0, 5'h00, 5'h05, 1'b0},
      '{5'h10, 1'b0, 5'h00, 5'h05, 1'b0},
      '{5'h10, 1'b0, 5'h00, 5'h05, 1'b0},
      '{5'h10, 1'b1, 5'h11, 5'h10, 1'b1},  // rotate mode entered
      '{5'h10, 1'b1, 5'h12, 5'h10, 1'b0},
      '{5'h10, 1'b0, 5'h00, 5'h10, 1'b0},
      '{5'h10, 1'b1, 5'h14, 5'h10, 1'b0},
      '{5'h10, 1'b0, 5'h00, 5'h10, 1'b0},
      '{5'h10, 1'b1, 5'h18, 5'h10, 1'b0},
      '{5'h10, 1'b0, 5'h00, 5'h10, 1'b0},
      '{5'h10, 1'b1, 5'h11, 5'h10, 1'b0},  // 1000 wraps to 0001
      '{5'h03, 1'b0, 5'h00, 5'h10, 1'b0},
      '{5'h03, 1'b1, 5'h12, 5'h10, 1'b0},  // still rotating while debouncing
      '{5'h03, 1'b1, 5'h03, 5'h03, 1'b1},  // back to mode 0
      '{5'h03, 1'b0, 5'h00, 5'h03, 1'b0}
    };

    // reset state
    enable = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_chipselect", {31'b0, avm_chipselect}, 32'h0);
    check("rst_write_n", {31'b0, avm_write_n}, 32'h1);
    check("rst_writedata", avm_writedata, 32'h0);
    check("rst_sw_value", {27'b0, sw_value}, 32'h0);
    check("rst_sw_changed", {31'b0, sw_changed}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_address", {30'b0, avm_address}, 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 24; i++)
      do_poll(vecs[i].din, vecs[i].wr_v, vecs[i].wr_d, vecs[i].sw, vecs[i].chg,
              i > 0, $sformatf("vec%0d", i));

    // enable dropped mid-transaction
    r = $urandom;
    avm_readdata = {r[31:5], 5'h03};
    wait_state(S_RD_DATA, 3 * POLL, ok);
    enable = 1'b0;
    wait_idle(10);
    @(negedge clk);
    check("endrop_sw_value", {27'b0, sw_value}, 32'h3);
    rc0 = rd_count;
    repeat (40) @(negedge clk);
    check("endrop_no_poll", rd_count - rc0, 0);
    check("endrop_busy", {31'b0, busy}, 32'h0);
    enable = 1'b1;
    en_cyc = cyc;
    do_poll(5'h03, 1'b0, 5'h00, 5'h03, 1'b0, 1'b0, "enrestart");
    check("enrestart_latency", poll_last_rd - en_cyc, POLL);

    // reset pulsed during WR
    do_poll(5'h07, 1'b0, 5'h00, 5'h03, 1'b0, 1'b1, "pre_rst0");
    do_poll(5'h07, 1'b0, 5'h00, 5'h03, 1'b0, 1'b1, "pre_rst1");
    exp_q.push_back(32'h7);
    wait_state(S_WR, 3 * POLL, ok);
    #2 reset_n = 1'b0;
    #1;
    check("wrrst_chipselect", {31'b0, avm_chipselect}, 32'h0);
    check("wrrst_write_n", {31'b0, avm_write_n}, 32'h1);
    check("wrrst_writedata", avm_writedata, 32'h0);
    check("wrrst_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    check("wrrst_sw_value", {27'b0, sw_value}, 32'h0);
    check("wrrst_exp_drained", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    do_poll(5'h07, 1'b1, 5'h00, 5'h00, 1'b0, 1'b0, "post_rst0");
    do_poll(5'h07, 1'b0, 5'h00, 5'h00, 1'b0, 1'b1, "post_rst1");
    do_poll(5'h07, 1'b1, 5'h07, 5'h07, 1'b1, 1'b1, "post_rst2");

    repeat (POLL + 8) @(negedge clk);
    check("final_exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d cycles, expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/led_dipsw_poller.md
LED_DIPSW_POLLER -- requirements
Module: led_dipsw_poller

Interface
REQ-001 Parameter POLL_CYCLES, default 50000: clock cycles between PIO poll transactions; legal range 8 or more.
REQ-002 Parameter DEBOUNCE_COUNT, default 4: consecutive identical samples needed to accept a switch value; legal range 1 to 15.
REQ-003 Parameter ROTATE_DIV, default 8: polls per rotate step in rotate mode; legal range 1 to 255.
REQ-004 clk  in  1  single clock; every register is clocked on the rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  polling enable.
REQ-007 avm_address  out  2  PIO register address; always 0.
REQ-008 avm_chipselect  out  1  PIO chipselect.
REQ-009 avm_write_n  out  1  PIO write strobe, active-low.
REQ-010 avm_writedata  out  32  PIO write data.
REQ-011 avm_readdata  in  32  PIO read data: registered, valid 1 cycle after address 0 is presented, no waitrequest.
REQ-012 sw_value  out  5  debounced DIP-switch value.
REQ-013 sw_changed  out  1  1-cycle pulse when sw_value updates.
REQ-014 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-015 Poll counter shall count 0..POLL_CYCLES-1 and wrap; tick is asserted in the cycle where count = POLL_CYCLES-1.
REQ-016 While enable=0, the poll counter shall be held at 0 and no tick shall be generated.
REQ-017 FSM states: IDLE, RD_ADDR, RD_DATA, EVAL, WR.
REQ-018 Transition IDLE->RD_ADDR on tick; RD_ADDR->RD_DATA; RD_DATA->EVAL; EVAL->WR if a write is required, else EVAL->IDLE; WR->IDLE.
REQ-019 A tick arriving while the FSM is not in IDLE shall be dropped; a transaction in progress shall complete even if enable falls.
REQ-020 RD_ADDR and RD_DATA: avm_chipselect=1, avm_write_n=1.
REQ-021 RD_DATA: sample = avm_readdata[4:0], captured at the end of the cycle.
REQ-022 Debounce, evaluated in EVAL, when sample != candidate: candidate<=sample, cnt<=1.
REQ-023 Debounce, evaluated in EVAL, when sample == candidate: cnt<=cnt+1, saturating at DEBOUNCE_COUNT.
REQ-024 When the updated cnt >= DEBOUNCE_COUNT and candidate differs from sw_value, sw_value<=candidate and sw_changed pulses in the following cycle; no pulse is generated when the accepted value equals sw_value.
REQ-025 LED value, mode 0 (sw_value[4]=0): led = sw_value.
REQ-026 LED value, mode 1 (sw_value[4]=1): led = {1'b1, rot[3:0]}.
REQ-027 rot is one-hot, reset to 4'b0001; in mode 1 it rotates left every ROTATE_DIV completed polls (4'b1000 wraps to 4'b0001); in mode 0 it is held at 4'b0001 and its divider is cleared.
REQ-028 led shall be computed from the sw_value and rot values after EVAL updates.
REQ-029 A write is required when led != last_led or when the force flag is set.
REQ-030 WR: avm_chipselect=1, avm_write_n=0, avm_writedata={27'b0, led}; in the same cycle last_led<=led and the force flag is cleared.
REQ-031 IDLE and EVAL: avm_chipselect=0, avm_write_n=1, avm_writedata=0.

Reset
REQ-032 Reset values: FSM=IDLE, poll counter=0, cnt=0, candidate=0, sw_value=0, sw_changed=0, busy=0, avm_chipselect=0, avm_write_n=1, avm_writedata=0, rot=4'b0001, rot divider=0, last_led=0, force flag=1.
REQ-033 Reset asserted mid-transaction shall abort it immediately; no partial write shall be issued after reset releases.

Verification (POLL_CYCLES=16, DEBOUNCE_COUNT=3, ROTATE_DIV=2)
REQ-034 Reset release, enable=1, readdata=0 -> first poll writes 0 (forced), then no writes while the input is constant; each RD_ADDR cycle starts 16 cycles after the previous one.
REQ-035 Input 0x05 held -> 3rd poll updates sw_value=0x05 with one sw_changed pulse; a write of 0x05 follows in WR of that poll.
REQ-036 Input alternating 0x05/0x06 per poll -> sw_value, sw_changed and write activity all unchanged.
REQ-037 Input 0x10 stable -> after acceptance, writes 0x11, 0x12, 0x14, 0x18, 0x11, one rotate step every 2 polls.
REQ-038 enable dropped during RD_DATA -> transaction completes, busy falls, no further RD_ADDR until enable returns; counter restarts from 0.
REQ-039 reset_n pulsed low during WR -> chipselect=0 asynchronously; after release the next poll performs a forced write.
